// File: rtl/primo_pkg.sv
// Shared constants and the elaboration-time primality function for the prime detector.
package primo_pkg;

    localparam int PRIMO_MAX_WIDTH = 10;
    localparam int PRIMO_CNT_W     = 16;

    // Trial division by every d with d*d <= value; only ever evaluated as a constant.
    function automatic logic is_prime(input int unsigned value);
        if (value < 2) begin
            return 1'b0;
        end
        for (int unsigned d = 2; d * d <= value; d++) begin
            if (value % d == 0) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/primo_table.sv
// Combinational operand -> prime-bit lookup.
// The table is a constant vector filled at elaboration, so no divider is built.
module primo_table
    import primo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] operand,
    output logic             prime
);

    localparam int DEPTH = 2 ** WIDTH;

    logic [DEPTH-1:0] table_bits;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign table_bits[gi] = is_prime(gi);
        end
    endgenerate

    assign prime = table_bits[operand];

endmodule

// File: rtl/primo_detector.sv
// Registered prime detector: one operand per cycle, result one cycle later.
// Define PRIMO_STATS_EN to add the saturating prime_count output.
module primo_detector
    import primo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       N,
    output logic                   out_valid,
    output logic                   F,
    output logic [WIDTH-1:0]       N_out
`ifdef PRIMO_STATS_EN
    ,
    output logic [PRIMO_CNT_W-1:0] prime_count
`endif
);

    generate
        if (WIDTH < 2 || WIDTH > PRIMO_MAX_WIDTH) begin : g_bad_width
            $error("primo_detector: WIDTH must be in 2..10");
        end
    endgenerate

    logic prime_bit;

    primo_table #(.WIDTH(WIDTH)) u_table (
        .operand (N),
        .prime   (prime_bit)
    );

    // F and N_out deliberately hold across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            F         <= 1'b0;
            N_out     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                F     <= prime_bit;
                N_out <= N;
            end
        end
    end

`ifdef PRIMO_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prime_count <= '0;
        end else if (in_valid && prime_bit && (prime_count != {PRIMO_CNT_W{1'b1}})) begin
            prime_count <= prime_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_primo_detector.sv
// Scoreboard bench for primo_detector (WIDTH=4 main instance, WIDTH=8 boundary instance).
module tb_primo_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] N;
    logic       out_valid;
    logic       F;
    logic [3:0] N_out;

    logic       in_valid8;
    logic [7:0] N8;
    logic       out_valid8;
    logic       F8;
    logic [7:0] N_out8;

`ifdef PRIMO_STATS_EN
    logic [15:0] prime_count;
    logic [15:0] prime_count8;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0] n;
        logic       f;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    primo_detector #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .N         (N),
        .out_valid (out_valid),
        .F         (F),
        .N_out     (N_out)
`ifdef PRIMO_STATS_EN
        ,
        .prime_count (prime_count)
`endif
    );

    primo_detector #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .N         (N8),
        .out_valid (out_valid8),
        .F         (F8),
        .N_out     (N_out8)
`ifdef PRIMO_STATS_EN
        ,
        .prime_count (prime_count8)
`endif
    );

    // Reference primality by divisor counting: prime iff exactly two divisors.
    function automatic logic ref_prime(input int n);
        int divs = 0;
        for (int k = 1; k <= n; k++) begin
            if (n % k == 0) divs++;
        end
        return (divs == 2);
    endfunction

    // Drive one cycle; expectation is queued only when the operand can be accepted.
    task automatic drive(input logic v, input logic [3:0] n, input logic r);
        rst_n    = r;
        in_valid = v;
        N        = n;
        if (v && r) begin
            exp_t e;
            e.n = n;
            e.f = ref_prime(int'(n));
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor samples on the falling edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: out_valid=1 with N_out=%0d, required no result", N_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total_cnt++;
                if (F !== e.f || N_out !== e.n) begin
                    $display("FAIL sb_result: F=%b N_out=%0d, required F=%b N_out=%0d", F, N_out, e.f, e.n);
                end else begin
                    pass_cnt++;
                    $display("result N=%0d F=%b", N_out, F);
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd7, 1'b0);
            total_cnt++;
            if (out_valid !== 1'b0 || F !== 1'b0 || N_out !== 4'd0) begin
                $display("FAIL reset_hold: out_valid=%b F=%b N_out=%0d, required 0 0 0", out_valid, F, N_out);
            end else begin
                pass_cnt++;
                $display("reset cycle %0d outputs cleared", i);
            end
        end
        drive(1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 1'b1);
        end
        drive(1'b0, 4'd0, 1'b1);
        drive(1'b0, 4'd0, 1'b1);
        total_cnt++;
        if (sb.size() != 0) begin
            $display("FAIL sweep_drain: pending=%0d, required 0", sb.size());
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] ops[4]  = '{4'd0, 4'd1, 4'd2, 4'd15};
        logic       fexp[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] ops8[2]  = '{8'd251, 8'd255};
        logic       fexp8[2] = '{1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 1'b1);
            total_cnt++;
            if (F !== fexp[i] || out_valid !== 1'b1) begin
                $display("FAIL boundary_w4: N=%0d F=%b out_valid=%b, required F=%b out_valid=1", ops[i], F, out_valid, fexp[i]);
            end else begin
                pass_cnt++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            in_valid8 = 1'b1;
            N8        = ops8[i];
            drive(1'b0, 4'd0, 1'b1);
            total_cnt++;
            if (F8 !== fexp8[i] || N_out8 !== ops8[i] || out_valid8 !== 1'b1) begin
                $display("FAIL boundary_w8: N=%0d F=%b N_out=%0d, required F=%b N_out=%0d", ops8[i], F8, N_out8, fexp8[i], ops8[i]);
            end else begin
                pass_cnt++;
                $display("w8 N=%0d F=%b", N_out8, F8);
            end
        end
        in_valid8 = 1'b0;
        drive(1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_gaps();
        logic ov_exp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic f_exp[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic v_seq[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] n_seq[4] = '{4'd5, 4'd0, 4'd0, 4'd9};
        for (int i = 0; i < 4; i++) begin
            drive(v_seq[i], n_seq[i], 1'b1);
            total_cnt++;
            if (out_valid !== ov_exp[i] || F !== f_exp[i]) begin
                $display("FAIL gap_cycle%0d: out_valid=%b F=%b, required out_valid=%b F=%b", i, out_valid, F, ov_exp[i], f_exp[i]);
            end else begin
                pass_cnt++;
            end
        end
        drive(1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 4'd3, 1'b1);
        drive(1'b1, 4'd5, 1'b1);
        drive(1'b1, 4'd7, 1'b0);
        total_cnt++;
        if (out_valid !== 1'b0 || F !== 1'b0 || N_out !== 4'd0) begin
            $display("FAIL midreset_clear: out_valid=%b F=%b N_out=%0d, required 0 0 0", out_valid, F, N_out);
        end else begin
            pass_cnt++;
        end
        drive(1'b0, 4'd0, 1'b1);
        total_cnt++;
        if (out_valid !== 1'b0 || N_out !== 4'd0 || sb.size() != 0) begin
            $display("FAIL midreset_after: out_valid=%b N_out=%0d pending=%0d, required 0 0 0", out_valid, N_out, sb.size());
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 1'b1);
            total_cnt++;
            if (out_valid !== 1'b1) begin
                $display("FAIL b2b_valid: cycle %0d out_valid=%b, required 1", i, out_valid);
            end else begin
                pass_cnt++;
            end
        end
        drive(1'b0, 4'd0, 1'b1);
        drive(1'b0, 4'd0, 1'b1);
    endtask

`ifdef PRIMO_STATS_EN
    task automatic test_stats();
        drive(1'b0, 4'd0, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                drive(1'b1, 4'(i), 1'b1);
            end
        end
        drive(1'b0, 4'd0, 1'b1);
        total_cnt++;
        if (prime_count !== 16'd12) begin
            $display("FAIL stats_count: prime_count=%0d, required 12", prime_count);
        end else begin
            pass_cnt++;
        end
        force dut.prime_count = 16'hFFFD;
        #1;
        release dut.prime_count;
        drive(1'b1, 4'd2, 1'b1);
        drive(1'b1, 4'd3, 1'b1);
        drive(1'b1, 4'd5, 1'b1);
        drive(1'b1, 4'd7, 1'b1);
        drive(1'b0, 4'd0, 1'b1);
        total_cnt++;
        if (prime_count !== 16'hFFFF) begin
            $display("FAIL stats_saturate: prime_count=%h, required ffff", prime_count);
        end else begin
            pass_cnt++;
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        N         = '0;
        in_valid8 = 1'b0;
        N8        = '0;
        #1;
        test_reset();
        test_sweep();
        test_boundaries();
        test_gaps();
        test_midstream_reset();
        test_back_to_back();
`ifdef PRIMO_STATS_EN
        test_stats();
`endif
        total_cnt++;
        if (sb.size() != 0) begin
            $display("FAIL final_drain: pending=%0d, required 0", sb.size());
        end else begin
            pass_cnt++;
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "timeout");
    end

endmodule
